// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder with a start/busy/done handshake.
// One full-adder cell plus a carry flop consumes one operand bit per clock,
// LSB first. The result (o_sum, o_cout) is published on the edge that enters
// DONE and is held until the next accepted start.
// Optional feature macro: SERIAL_ADDER_OVF_EN adds the o_ovf signed-overflow port.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             o_cout,
    output logic             o_ovf
`else
    output logic             o_cout
`endif
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One full-adder cell: returns {carry_out, sum_bit}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        full_add = {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
    endfunction

    state_t             r_state;
    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic [WIDTH-1:0]   r_sum_sr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_carry;

    logic [1:0]         w_fa;
    logic               w_s;
    logic               w_c;
    logic [WIDTH-1:0]   w_sum_next;
    logic               w_last;

    // Full-adder datapath on the current LSBs and the final-bit detect.
    always_comb begin
        w_fa       = full_add(r_a_sr[0], r_b_sr[0], r_carry);
        w_s        = w_fa[0];
        w_c        = w_fa[1];
        w_sum_next = {w_s, r_sum_sr[WIDTH-1:1]};
        if ((r_state == ST_RUN) && (r_cnt == CNT_W'(WIDTH - 1))) begin
            w_last = 1'b1;
        end else begin
            w_last = 1'b0;
        end
    end

    // Control FSM, operand/sum shift registers and registered handshake outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_a_sr   <= {WIDTH{1'b0}};
            r_b_sr   <= {WIDTH{1'b0}};
            r_sum_sr <= {WIDTH{1'b0}};
            r_cnt    <= {CNT_W{1'b0}};
            r_carry  <= 1'b0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_sum    <= {WIDTH{1'b0}};
            o_cout   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        r_a_sr   <= i_a;
                        r_b_sr   <= i_b;
                        r_carry  <= i_cin;
                        r_cnt    <= {CNT_W{1'b0}};
                        r_sum_sr <= {WIDTH{1'b0}};
                        o_busy   <= 1'b1;
                        r_state  <= ST_RUN;
                    end else begin
                        o_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // A start seen here is deliberately dropped, not queued.
                    r_sum_sr <= w_sum_next;
                    r_carry  <= w_c;
                    r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
                    r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
                    r_cnt    <= r_cnt + CNT_W'(1'b1);
                    if (w_last) begin
                        o_sum   <= w_sum_next;
                        o_cout  <= w_c;
                        o_busy  <= 1'b0;
                        o_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        o_busy  <= 1'b1;
                        o_done  <= 1'b0;
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    o_busy  <= 1'b0;
                    o_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    // Signed overflow: carry into the MSB differs from carry out of the MSB.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ovf <= 1'b0;
        end else if (w_last) begin
            o_ovf <= r_carry ^ w_c;
        end else begin
            o_ovf <= o_ovf;
        end
    end
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed WIDTH=8 scenarios plus an
// exhaustive WIDTH=4 sweep. Expected results are queued when an operation is
// started and popped when the DUT pulses done.
// Build with SERIAL_ADDER_OVF_EN defined to also check the o_ovf port.
module tb_serial_adder;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic       clk;
    logic       rst_n;

    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start4, cin4, busy4, done4, cout4;
    logic [3:0] a4, b4, sum4;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf8, ovf4;
`endif

    exp_t q8[$];
    exp_t q4[$];
    int   n_vec;
    int   n_fail;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start8),
        .i_a     (a8),
        .i_b     (b8),
        .i_cin   (cin8),
        .o_busy  (busy8),
        .o_done  (done8),
        .o_sum   (sum8),
`ifdef SERIAL_ADDER_OVF_EN
        .o_cout  (cout8),
        .o_ovf   (ovf8)
`else
        .o_cout  (cout8)
`endif
    );

    serial_adder #(.WIDTH(4)) u_dut4 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start4),
        .i_a     (a4),
        .i_b     (b4),
        .i_cin   (cin4),
        .o_busy  (busy4),
        .o_done  (done4),
        .o_sum   (sum4),
`ifdef SERIAL_ADDER_OVF_EN
        .o_cout  (cout4),
        .o_ovf   (ovf4)
`else
        .o_cout  (cout4)
`endif
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference arithmetic: integer add, signed overflow from operand/result signs.
    function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b, input logic ci);
        logic [32:0] t;
        exp_t        e;
        t      = {1'b0, a} + {1'b0, b} + {32'd0, ci};
        e.sum  = t[31:0] & ((32'd1 << w) - 32'd1);
        e.cout = t[w];
        e.ovf  = (a[w-1] == b[w-1]) && (t[w-1] != a[w-1]);
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op8(input logic [7:0] a, input logic [7:0] b, input logic ci);
        a8 = a; b8 = b; cin8 = ci; start8 = 1'b1;
        q8.push_back(model(8, {24'd0, a}, {24'd0, b}, ci));
    endtask

    // Called one tick after the start edge; n = edges after the start edge until done.
    task automatic wait_done8(output int n);
        n = 0;
        while (done8 !== 1'b1 && n < 40) begin
            check("busy8_run", {63'd0, busy8}, 64'd1);
            tick();
            n++;
        end
        check("done8_seen", {63'd0, done8}, 64'd1);
    endtask

    task automatic chk_result8(input string tag);
        exp_t e;
        check({tag, "_sb_nonempty"}, {63'd0, (q8.size() != 0)}, 64'd1);
        if (q8.size() != 0) begin
            e = q8.pop_front();
            check({tag, "_sum"}, {56'd0, sum8}, {32'd0, e.sum});
            check({tag, "_cout"}, {63'd0, cout8}, {63'd0, e.cout});
`ifdef SERIAL_ADDER_OVF_EN
            check({tag, "_ovf"}, {63'd0, ovf8}, {63'd0, e.ovf});
`endif
        end
    endtask

    initial begin
        int   n;
        exp_t e;
        n_vec  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        start8 = 1'b0; a8 = 8'd0; b8 = 8'd0; cin8 = 1'b0;
        start4 = 1'b0; a4 = 4'd0; b4 = 4'd0; cin4 = 1'b0;

        // Reset state.
        tick();
        tick();
        check("rst_busy", {63'd0, busy8}, 64'd0);
        check("rst_done", {63'd0, done8}, 64'd0);
        check("rst_sum", {56'd0, sum8}, 64'd0);
        check("rst_cout", {63'd0, cout8}, 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("rst_ovf", {63'd0, ovf8}, 64'd0);
`endif
        rst_n = 1'b1;
        tick();

        // Basic add 0x5A + 0x3C; done in the (WIDTH+1)th cycle from the start edge.
        start_op8(8'h5A, 8'h3C, 1'b0);
        tick();
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        wait_done8(n);
        check("basic_latency", 64'(n), 64'd8);
        check("basic_busy_low", {63'd0, busy8}, 64'd0);
        chk_result8("basic");
        tick();
        check("basic_done_pulse", {63'd0, done8}, 64'd0);
        check("basic_sum_held", {56'd0, sum8}, 64'h96);

        // Carry chain 0xFF + 0x01, then 0 + 0 + cin.
        start_op8(8'hFF, 8'h01, 1'b0);
        tick();
        start8 = 1'b0;
        wait_done8(n);
        chk_result8("carry");
        start_op8(8'h00, 8'h00, 1'b1);
        tick();
        start8 = 1'b0;
        wait_done8(n);
        chk_result8("cin_only");
        tick();

        // Ignored start during RUN: not queued, single done.
        start_op8(8'h10, 8'h20, 1'b0);
        tick();
        start8 = 1'b0;
        tick();
        tick();
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        wait_done8(n);
        chk_result8("ignored");
        for (int i = 0; i < 12; i++) begin
            tick();
            check("ignored_no_2nd_done", {63'd0, done8}, 64'd0);
        end
        check("ignored_idle_busy", {63'd0, busy8}, 64'd0);

        // Back-to-back: second start presented in the done cycle.
        start_op8(8'h7F, 8'h7F, 1'b0);
        tick();
        start8 = 1'b0;
        wait_done8(n);
        chk_result8("b2b_first");
        check("b2b_busy_low_in_done", {63'd0, busy8}, 64'd0);
        start_op8(8'h80, 8'h80, 1'b0);
        tick();
        start8 = 1'b0;
        check("b2b_busy_restart", {63'd0, busy8}, 64'd1);
        wait_done8(n);
        check("b2b_spacing", 64'(n), 64'd8);
        chk_result8("b2b_second");
        tick();

        // Establish a nonzero held result, then reset in the middle of a run.
        start_op8(8'hF0, 8'h20, 1'b0);
        tick();
        start8 = 1'b0;
        wait_done8(n);
        chk_result8("pre_reset");
        tick();
        start_op8(8'h55, 8'h33, 1'b0);
        tick();
        start8 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {63'd0, busy8}, 64'd0);
        check("midrst_done", {63'd0, done8}, 64'd0);
        check("midrst_sum", {56'd0, sum8}, 64'd0);
        check("midrst_cout", {63'd0, cout8}, 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("midrst_ovf", {63'd0, ovf8}, 64'd0);
`endif
        e = q8.pop_back();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("midrst_no_done", {63'd0, done8}, 64'd0);
        end

        // Recovery after reset.
        start_op8(8'hA5, 8'h5A, 1'b1);
        tick();
        start8 = 1'b0;
        wait_done8(n);
        chk_result8("post_reset");
        tick();

        // Exhaustive WIDTH=4 sweep, next start issued in each done cycle.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    a4 = 4'(ia); b4 = 4'(ib); cin4 = 1'(ic); start4 = 1'b1;
                    q4.push_back(model(4, 32'(ia), 32'(ib), 1'(ic)));
                    tick();
                    start4 = 1'b0;
                    n = 0;
                    while (done4 !== 1'b1 && n < 20) begin
                        tick();
                        n++;
                    end
                    check("sweep_done", {63'd0, done4}, 64'd1);
                    check("sweep_latency", 64'(n), 64'd4);
                    e = q4.pop_front();
                    check("sweep_sum", {60'd0, sum4}, {32'd0, e.sum});
                    check("sweep_cout", {63'd0, cout4}, {63'd0, e.cout});
`ifdef SERIAL_ADDER_OVF_EN
                    check("sweep_ovf", {63'd0, ovf4}, {63'd0, e.ovf});
`endif
                end
            end
        end
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
